// File: rtl/param_seq_detector.sv
// Serial bit-sequence detector with a runtime-loadable pattern.
// Supports overlapping or non-overlapping matches and has a saturating match counter.
module param_seq_detector #(
  parameter int                 PAT_W   = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_W-1:0]   RST_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FULL_M1 = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic {
    S_FILL,
    S_ARMED
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;
  logic [PAT_W-1:0]   cand;
  logic               hit;

  assign cand = {hist_q[PAT_W-2:0], i};

  // fill gates the compare so bits from before a restart never count
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    hit    = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = cand;
      hit    = (fill_q >= FULL_M1) && (cand == pat_q);
      if (hit && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else if (hit) begin
        fill_d = FULL;
      end else if (fill_q != FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (!pat_load && en && (fill_d == FULL))
          state_d = S_ARMED;
      end
      S_ARMED: begin
        if (pat_load || (hit && !overlap))
          state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    match_d = hit;
    cnt_d   = cnt_q;
    if (clr_cnt)
      cnt_d = hit ? CNT_W'(1) : '0;
    else if (hit && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FILL;
      pat_q   <= RST_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = (cnt_q == CNT_MAX);
  assign armed     = (state_q == S_ARMED);

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector.
// Uses a vector table on an 8-bit-counter instance and hand sequences on a 2-bit one.
module tb_param_seq_detector;

  logic       clk = 1'b0;
  logic       rst, en, i, pat_load, overlap, clr_cnt;
  logic [3:0] pat_in;
  logic       m0, sat0, arm0, m1, sat1, arm1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  param_seq_detector #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) dut0 (
    .clk(clk), .rst(rst), .en(en), .i(i), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .clr_cnt(clr_cnt),
    .match(m0), .match_cnt(cnt0), .cnt_sat(sat0), .armed(arm0)
  );

  param_seq_detector #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) dut1 (
    .clk(clk), .rst(rst), .en(en), .i(i), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .clr_cnt(clr_cnt),
    .match(m1), .match_cnt(cnt1), .cnt_sat(sat1), .armed(arm1)
  );

  typedef struct {
    logic       rst, en, i, ld;
    logic [3:0] pin;
    logic       ov, clr;
    logic       m;
    logic [7:0] cnt;
    logic       arm;
  } vec_t;

  vec_t tv[$];

  function automatic void v(input logic r, e, b, l, input logic [3:0] p,
                            input logic o, c, mm, input logic [7:0] cn,
                            input logic a);
    vec_t t;
    t.rst = r; t.en = e; t.i = b; t.ld = l; t.pin = p;
    t.ov = o; t.clr = c; t.m = mm; t.cnt = cn; t.arm = a;
    tv.push_back(t);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, b, l, input logic [3:0] p,
                       input logic o, c);
    rst = r; en = e; i = b; pat_load = l; pat_in = p;
    overlap = o; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s;
    int          hits;
    logic [1:0]  ecnt;

    rst = 0; en = 0; i = 0; pat_load = 0; pat_in = 0; overlap = 1; clr_cnt = 0;

    // reset
    v(0,0,0,0,4'h0,1,0, 0,0,0);
    v(0,0,0,0,4'h0,1,0, 0,0,0);
    // overlap stream 1011011
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,0,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 1,1,1);
    v(1,1,0,0,4'h0,1,0, 0,1,1);
    v(1,1,1,0,4'h0,1,0, 0,1,1);
    v(1,1,1,0,4'h0,1,0, 1,2,1);
    // non-overlap, same stream
    v(0,0,0,0,4'h0,0,0, 0,0,0);
    v(1,1,1,0,4'h0,0,0, 0,0,0);
    v(1,1,0,0,4'h0,0,0, 0,0,0);
    v(1,1,1,0,4'h0,0,0, 0,0,0);
    v(1,1,1,0,4'h0,0,0, 1,1,0);
    v(1,1,0,0,4'h0,0,0, 0,1,0);
    v(1,1,1,0,4'h0,0,0, 0,1,0);
    v(1,1,1,0,4'h0,0,0, 0,1,0);
    // en gaps with toggling i
    v(0,0,0,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,0,0,0,4'h0,1,0, 0,0,0);
    v(1,0,1,0,4'h0,1,0, 0,0,0);
    v(1,1,0,0,4'h0,1,0, 0,0,0);
    v(1,0,1,0,4'h0,1,0, 0,0,0);
    v(1,0,1,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,0,0,0,4'h0,1,0, 0,0,0);
    v(1,0,1,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 1,1,1);
    v(1,0,1,0,4'h0,1,0, 0,1,1);
    // pattern load mid-stream
    v(0,0,0,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,0,0,4'h0,1,0, 0,0,0);
    v(1,1,1,1,4'h6,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,0,0,4'h0,1,0, 0,0,0);
    v(1,1,0,0,4'h0,1,0, 0,0,1);
    v(1,1,1,0,4'h0,1,0, 0,0,1);
    v(1,1,1,0,4'h0,1,0, 0,0,1);
    v(1,1,0,0,4'h0,1,0, 1,1,1);
    v(1,1,1,0,4'h0,1,0, 0,1,1);
    v(1,1,1,0,4'h0,1,0, 0,1,1);
    v(1,1,0,0,4'h0,1,0, 1,2,1);
    v(1,1,1,1,4'h1,1,0, 0,2,0);
    v(1,0,0,0,4'h0,1,1, 0,0,0);
    // reset mid-stream restores 1011 and beats pat_load
    v(0,0,0,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,0,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(0,1,1,1,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,0,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 0,0,0);
    v(1,1,1,0,4'h0,1,0, 1,1,1);
    v(1,1,0,1,4'h0,1,0, 0,1,0);
    v(1,1,0,0,4'h0,1,0, 0,1,0);
    v(1,1,0,0,4'h0,1,0, 0,1,0);
    v(1,1,0,0,4'h0,1,0, 0,1,0);
    v(1,1,0,0,4'h0,1,0, 1,2,1);
    v(1,1,0,0,4'h0,1,0, 1,3,1);
    v(1,1,0,0,4'h0,0,0, 1,4,0);
    v(1,1,0,0,4'h0,0,0, 0,4,0);

    for (int k = 0; k < tv.size(); k++) begin
      drive(tv[k].rst, tv[k].en, tv[k].i, tv[k].ld, tv[k].pin,
            tv[k].ov, tv[k].clr);
      chk("match", k, 32'(m0), 32'(tv[k].m));
      chk("match_cnt", k, 32'(cnt0), 32'(tv[k].cnt));
      chk("armed", k, 32'(arm0), 32'(tv[k].arm));
      chk("cnt_sat", k, 32'(sat0), 32'(tv[k].cnt == 8'hff));
    end

    // 2-bit counter: five overlapping hits saturate at 3
    drive(0,0,0,0,4'h0,1,0);
    chk("sat_rst_cnt", 0, 32'(cnt1), 0);
    chk("sat_rst_flag", 0, 32'(sat1), 0);
    s    = 16'b1011_0110_1101_1011;
    hits = 0;
    ecnt = 2'd0;
    for (int k = 0; k < 16; k++) begin
      drive(1,1,s[15-k],0,4'h0,1,0);
      if (k >= 3 && (k % 3) == 0) begin
        hits++;
        if (ecnt != 2'd3) ecnt = ecnt + 2'd1;
      end
      chk("sat_match", k, 32'(m1), 32'(k >= 3 && (k % 3) == 0));
      chk("sat_cnt", k, 32'(cnt1), 32'(ecnt));
    end
    chk("sat_hits", 0, 32'(hits), 5);
    chk("sat_flag", 0, 32'(sat1), 1);
    // clr_cnt coincident with a sixth hit leaves the count at one
    drive(1,1,0,0,4'h0,1,0);
    drive(1,1,1,0,4'h0,1,0);
    drive(1,1,1,0,4'h0,1,1);
    chk("clr_hit_match", 0, 32'(m1), 1);
    chk("clr_hit_cnt", 0, 32'(cnt1), 1);
    chk("clr_hit_sat", 0, 32'(sat1), 0);
    drive(1,0,0,0,4'h0,1,0);
    chk("post_clr_match", 0, 32'(m1), 0);
    chk("post_clr_cnt", 0, 32'(cnt1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
